// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Groups the ID-stage issue/branch/kill request and the stall response of the
// hazard scoreboard into one bundle.
//   master modport : the decode stage; drives the instruction fields and
//                    receives the stall/cause/busy outputs.
//   slave modport  : the scoreboard itself.
// Signals
//   i_issue_valid, i_re_rs, i_re_rt, i_rs, i_rt   instruction sources
//   i_issue_wen, i_issue_ws, i_issue_lat          instruction destination
//   i_branch_en, i_kill                           branch stall / flush
//   o_stall_en, o_raw_stall, o_waw_stall,
//   o_br_stall, o_busy_mask                       stall decision and causes
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int ADDR_REG  = 5,
   parameter int LAT_WIDTH = 4
);
   logic                     i_issue_valid;
   logic                     i_re_rs;
   logic                     i_re_rt;
   logic [ADDR_REG-1:0]      i_rs;
   logic [ADDR_REG-1:0]      i_rt;
   logic                     i_issue_wen;
   logic [ADDR_REG-1:0]      i_issue_ws;
   logic [LAT_WIDTH-1:0]     i_issue_lat;
   logic                     i_branch_en;
   logic                     i_kill;
   logic                     o_stall_en;
   logic                     o_raw_stall;
   logic                     o_waw_stall;
   logic                     o_br_stall;
   logic [2**ADDR_REG-1:0]   o_busy_mask;

   modport master (
      output i_issue_valid, i_re_rs, i_re_rt, i_rs, i_rt,
             i_issue_wen, i_issue_ws, i_issue_lat, i_branch_en, i_kill,
      input  o_stall_en, o_raw_stall, o_waw_stall, o_br_stall, o_busy_mask
   );

   modport slave (
      input  i_issue_valid, i_re_rs, i_re_rt, i_rs, i_rt,
             i_issue_wen, i_issue_ws, i_issue_lat, i_branch_en, i_kill,
      output o_stall_en, o_raw_stall, o_waw_stall, o_br_stall, o_busy_mask
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// ID-stage stall unit built on a per-register scoreboard of result-latency
// countdowns. Each register holds the number of cycles until its pending
// result becomes forwardable; a reader of a non-zero entry stalls (RAW), and a
// writer whose result would land before an older pending write stalls (WAW).
// A programmable branch stall and a kill/flush input are also handled.
// Ports
//   i_clk    clock, all state on the rising edge
//   i_rst_n  synchronous active-low reset; all outputs forced to 0 while low
//   sb       hazard_scoreboard_if.slave: instruction fields in, stall out
// Parameters
//   ADDR_REG      register address width (NUM_REGS = 2**ADDR_REG)
//   LAT_WIDTH     width of each countdown and of i_issue_lat
//   BRANCH_STALL  stall cycles per taken branch (0 disables branch stalls)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int ADDR_REG     = 5,
   parameter int LAT_WIDTH    = 4,
   parameter int BRANCH_STALL = 1
) (
   input logic               i_clk,
   input logic               i_rst_n,
   hazard_scoreboard_if.slave sb
);

   localparam int NUM_REGS = 2**ADDR_REG;
   localparam int BR_W     = (BRANCH_STALL > 0) ? $clog2(BRANCH_STALL + 1) : 1;
   localparam logic BR_ON  = (BRANCH_STALL != 0);
   localparam logic [BR_W-1:0] BR_LOAD =
      (BRANCH_STALL > 0) ? BR_W'(BRANCH_STALL - 1) : '0;

   logic [LAT_WIDTH-1:0] cnt [NUM_REGS];
   logic [BR_W-1:0]      br_cnt;
   logic [NUM_REGS-1:0]  busy;
   logic                 raw;
   logic                 waw;
   logic                 br;
   logic                 stall;
   logic                 accept;

   // Busy vector straight from the countdowns; r0 is hard-wired idle so reads
   // of r0 can never stall.
   always_comb begin
      busy = '0;
      for (int n = 1; n < NUM_REGS; n++) begin
         busy[n] = (cnt[n] != '0);
      end
   end

   // Hazard detection works on pre-issue state, so an instruction whose source
   // equals its own destination only sees the older producer. WAW stalls only
   // when the older write would still be pending after the new one finishes.
   always_comb begin
      raw    = sb.i_issue_valid &
               ((sb.i_re_rs & busy[sb.i_rs]) | (sb.i_re_rt & busy[sb.i_rt]));
      waw    = sb.i_issue_valid & sb.i_issue_wen & (sb.i_issue_ws != '0) &
               (cnt[sb.i_issue_ws] > sb.i_issue_lat);
      br     = BR_ON & (sb.i_branch_en | (br_cnt != '0));
      stall  = raw | waw | br;
      accept = sb.i_issue_valid & ~stall & ~sb.i_kill;
   end

   // Outputs are the zero-latency stall path, masked to 0 during reset.
   always_comb begin
      sb.o_raw_stall = i_rst_n & raw;
      sb.o_waw_stall = i_rst_n & waw;
      sb.o_br_stall  = i_rst_n & br;
      sb.o_stall_en  = i_rst_n & stall;
      sb.o_busy_mask = i_rst_n ? busy : '0;
   end

   // Countdown update: reset and kill both wipe the board; an accepted write
   // loads its latency; otherwise every non-zero entry counts down by one.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || sb.i_kill) begin
         for (int n = 0; n < NUM_REGS; n++) begin
            cnt[n] <= '0;
         end
      end else begin
         cnt[0] <= '0;
         for (int n = 1; n < NUM_REGS; n++) begin
            if (accept && sb.i_issue_wen && (sb.i_issue_ws == ADDR_REG'(n))) begin
               cnt[n] <= sb.i_issue_lat;
            end else if (cnt[n] != '0) begin
               cnt[n] <= cnt[n] - 1'b1;
            end
         end
      end
   end

   // Branch window: the cycle of i_branch_en stalls by itself, br_cnt covers
   // the remaining BRANCH_STALL-1 cycles. A branch inside the window is
   // absorbed rather than reloading the counter.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || sb.i_kill || !BR_ON) begin
         br_cnt <= '0;
      end else if (br_cnt != '0) begin
         br_cnt <= br_cnt - 1'b1;
      end else if (sb.i_branch_en) begin
         br_cnt <= BR_LOAD;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard. The driver applies one request per
// cycle, predicts the outputs from a reference model that tracks, per
// register, the absolute cycle at which its pending result becomes available,
// and queues the prediction. A monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   localparam int AW = 5;
   localparam int LW = 4;
   localparam int BS = 3;
   localparam int NR = 2**AW;

   typedef struct packed {
      logic          rst_n;
      logic          valid;
      logic          re_rs;
      logic          re_rt;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          wen;
      logic [AW-1:0] ws;
      logic [LW-1:0] lat;
      logic          branch;
      logic          kill;
   } stim_t;

   typedef struct packed {
      logic          stall;
      logic          raw;
      logic          waw;
      logic          br;
      logic [NR-1:0] busy;
   } exp_t;

   logic clk;
   logic rst_n;

   hazard_scoreboard_if #(.ADDR_REG(AW), .LAT_WIDTH(LW)) sb_if ();

   hazard_scoreboard #(.ADDR_REG(AW), .LAT_WIDTH(LW), .BRANCH_STALL(BS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .sb      (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: ready_at[n] is the first cycle in which register n
   // is no longer pending; br_end is the first cycle after the branch window.
   int   ready_at [NR];
   int   br_end;
   int   cyc;
   exp_t exp_q [$];
   int   total;
   int   bad;
   logic last_accept;

   function automatic stim_t idle();
      stim_t s;
      s       = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic int remaining(input int n);
      if (n == 0) return 0;
      return (ready_at[n] > cyc) ? ready_at[n] - cyc : 0;
   endfunction

   function automatic exp_t predict(input stim_t s);
      exp_t e;
      e = '0;
      for (int n = 0; n < NR; n++) e.busy[n] = (remaining(n) != 0);
      e.raw   = s.valid && ((s.re_rs && remaining(int'(s.rs)) != 0) ||
                            (s.re_rt && remaining(int'(s.rt)) != 0));
      e.waw   = s.valid && s.wen && (s.ws != 0) && (remaining(int'(s.ws)) > int'(s.lat));
      e.br    = (BS != 0) && (s.branch || (cyc < br_end));
      e.stall = e.raw || e.waw || e.br;
      return e;
   endfunction

   // Drive one cycle of stimulus, queue the prediction, then advance the model
   // across the rising edge.
   task automatic apply_stimulus(input stim_t s);
      exp_t e;
      rst_n                = s.rst_n;
      sb_if.i_issue_valid  = s.valid;
      sb_if.i_re_rs        = s.re_rs;
      sb_if.i_re_rt        = s.re_rt;
      sb_if.i_rs           = s.rs;
      sb_if.i_rt           = s.rt;
      sb_if.i_issue_wen    = s.wen;
      sb_if.i_issue_ws     = s.ws;
      sb_if.i_issue_lat    = s.lat;
      sb_if.i_branch_en    = s.branch;
      sb_if.i_kill         = s.kill;
      e           = predict(s);
      last_accept = s.rst_n && s.valid && !e.stall && !s.kill;
      exp_q.push_back(s.rst_n ? e : exp_t'('0));
      @(posedge clk);
      if (!s.rst_n || s.kill) begin
         for (int n = 0; n < NR; n++) ready_at[n] = 0;
         br_end = 0;
      end else begin
         if (last_accept && s.wen && s.ws != 0) ready_at[s.ws] = cyc + 1 + int'(s.lat);
         if ((BS != 0) && s.branch && !(cyc < br_end)) br_end = cyc + BS;
      end
      cyc++;
      #1;
   endtask

   // Hold an instruction until the model accepts it, bounded.
   task automatic issue_until_accepted(input stim_t s, input int limit);
      int n;
      n = 0;
      last_accept = 1'b0;
      while (!last_accept && n < limit) begin
         apply_stimulus(s);
         n++;
      end
      if (!last_accept) begin
         total++;
         bad++;
         $display("[TB] FAIL issue_bound: got no acceptance after %0d cycles, expected acceptance", limit);
      end
   endtask

   task automatic check_output(input exp_t e);
      total++;
      if (sb_if.o_stall_en !== e.stall) begin
         bad++;
         $display("[TB] FAIL stall_en cyc=%0d: got %b expected %b", cyc, sb_if.o_stall_en, e.stall);
      end
      total++;
      if (sb_if.o_raw_stall !== e.raw) begin
         bad++;
         $display("[TB] FAIL raw_stall cyc=%0d: got %b expected %b", cyc, sb_if.o_raw_stall, e.raw);
      end
      total++;
      if (sb_if.o_waw_stall !== e.waw) begin
         bad++;
         $display("[TB] FAIL waw_stall cyc=%0d: got %b expected %b", cyc, sb_if.o_waw_stall, e.waw);
      end
      total++;
      if (sb_if.o_br_stall !== e.br) begin
         bad++;
         $display("[TB] FAIL br_stall cyc=%0d: got %b expected %b", cyc, sb_if.o_br_stall, e.br);
      end
      total++;
      if (sb_if.o_busy_mask !== e.busy) begin
         bad++;
         $display("[TB] FAIL busy_mask cyc=%0d: got %h expected %h", cyc, sb_if.o_busy_mask, e.busy);
      end
   endtask

   // Monitor: the DUT presents a decision every cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) check_output(exp_q.pop_front());
   end

   initial begin
      stim_t s;
      int    wait_cnt;
      total = 0;
      bad   = 0;
      cyc   = 0;
      br_end = 0;
      for (int n = 0; n < NR; n++) ready_at[n] = 0;

      s = idle();
      s.rst_n = 1'b0;
      rst_n = 1'b0;
      sb_if.i_issue_valid = 1'b0; sb_if.i_re_rs = 1'b0; sb_if.i_re_rt = 1'b0;
      sb_if.i_rs = '0; sb_if.i_rt = '0; sb_if.i_issue_wen = 1'b0;
      sb_if.i_issue_ws = '0; sb_if.i_issue_lat = '0;
      sb_if.i_branch_en = 1'b0; sb_if.i_kill = 1'b0;
      @(posedge clk); #1;
      $display("[TB] reset");
      for (int i = 0; i < 3; i++) apply_stimulus(s);

      $display("[TB] load-use RAW");
      s = idle(); s.valid = 1; s.wen = 1; s.ws = 3; s.lat = 2;
      apply_stimulus(s);
      s = idle(); s.valid = 1; s.re_rs = 1; s.rs = 3; s.re_rt = 1; s.rt = 1; s.wen = 1; s.ws = 4;
      issue_until_accepted(s, 10);

      $display("[TB] WAW ordering");
      s = idle(); s.valid = 1; s.wen = 1; s.ws = 5; s.lat = 9;
      apply_stimulus(s);
      s = idle(); s.valid = 1; s.wen = 1; s.ws = 5; s.lat = 1;
      issue_until_accepted(s, 20);
      s = idle(); s.valid = 1; s.re_rs = 1; s.rs = 5; s.wen = 1; s.ws = 6;
      issue_until_accepted(s, 20);

      $display("[TB] r0 never busy");
      s = idle(); s.valid = 1; s.wen = 1; s.ws = 0; s.lat = 5;
      apply_stimulus(s);
      s = idle(); s.valid = 1; s.re_rs = 1; s.rs = 0; s.re_rt = 1; s.rt = 0;
      apply_stimulus(s);
      apply_stimulus(idle());

      $display("[TB] branch window");
      s = idle(); s.branch = 1;
      apply_stimulus(s);
      apply_stimulus(idle());
      apply_stimulus(s);
      for (int i = 0; i < 3; i++) apply_stimulus(idle());

      $display("[TB] kill");
      s = idle(); s.valid = 1; s.wen = 1; s.ws = 7; s.lat = 6;
      apply_stimulus(s);
      s = idle(); s.valid = 1; s.wen = 1; s.ws = 9; s.lat = 3; s.kill = 1;
      apply_stimulus(s);
      s = idle(); s.valid = 1; s.re_rs = 1; s.rs = 7; s.re_rt = 1; s.rt = 9;
      apply_stimulus(s);

      $display("[TB] reset mid-countdown");
      s = idle(); s.valid = 1; s.wen = 1; s.ws = 8; s.lat = 7;
      apply_stimulus(s);
      apply_stimulus(idle());
      s = idle(); s.rst_n = 0; s.valid = 1; s.re_rs = 1; s.rs = 8;
      apply_stimulus(s);
      s = idle(); s.valid = 1; s.re_rs = 1; s.rs = 8;
      apply_stimulus(s);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         s        = idle();
         s.rst_n  = ($urandom_range(0, 99) >= 2);
         s.valid  = ($urandom_range(0, 99) < 70);
         s.re_rs  = $urandom_range(0, 1);
         s.re_rt  = $urandom_range(0, 1);
         s.rs     = AW'($urandom_range(0, 7));
         s.rt     = AW'($urandom_range(0, 7));
         s.wen    = $urandom_range(0, 1);
         s.ws     = AW'($urandom_range(0, 7));
         s.lat    = LW'($urandom_range(0, 15));
         s.branch = ($urandom_range(0, 99) < 5);
         s.kill   = ($urandom_range(0, 99) < 3);
         apply_stimulus(s);
      end
      apply_stimulus(idle());

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
